button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer_if.sv | 9 +
 rtl/button_debouncer.sv | 78 +++++++
 tb/tb_button_debouncer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Pushbutton-side signal bundle: raw active-low button in, debounced level and busy out.
interface button_debouncer_if;
    logic B_raw;
    logic B_db;
    logic busy;

    modport master (output B_raw, input B_db, input busy);
    modport slave  (input B_raw, output B_db, output busy);
endinterface

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: 2-flop synchronizer followed by a 4-state qualify FSM that
// accepts a level change only after STABLE_CYCLES consecutive matching samples.
module button_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst,
    button_debouncer_if.slave   bus
);

    typedef enum logic [1:0] {REL, CHK_PRESS, PRESSED, CHK_REL} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic             s1_q, s2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             b_db_q, b_db_d;
    logic             busy_q, busy_d;

    // cnt_inc counts the sample being taken this edge, so acceptance lands
    // exactly on the STABLE_CYCLES-th qualifying sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        cnt_inc = cnt_q + CNT_W'(1);
        case (state_q)
            REL: begin
                if (!s2_q) begin
                    state_d = CHK_PRESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_PRESS: begin
                if (s2_q)                  state_d = REL;
                else if (cnt_inc >= CNT_MAX) state_d = PRESSED;
                else                       cnt_d   = cnt_inc;
            end
            PRESSED: begin
                if (s2_q) begin
                    state_d = CHK_REL;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_REL: begin
                if (!s2_q)                 state_d = PRESSED;
                else if (cnt_inc >= CNT_MAX) state_d = REL;
                else                       cnt_d   = cnt_inc;
            end
            default: state_d = REL;
        endcase
        b_db_d = !(state_d == PRESSED || state_d == CHK_REL);
        busy_d = (state_d == CHK_PRESS || state_d == CHK_REL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= REL;
            cnt_q   <= '0;
            b_db_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            s1_q    <= bus.B_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_db_q  <= b_db_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.B_db = b_db_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized + directed bench for button_debouncer; a run-length reference model feeds
// a scoreboard queue that a separate monitor drains after every clock edge.
module tb_button_debouncer;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    button_debouncer_if bus ();

    button_debouncer #(.STABLE_CYCLES(S), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // expectation per edge: {B_db, busy}
    logic [1:0] exp_q[$];

    // Reference model: the debouncer sees B_raw two edges late; a run of S
    // consecutive samples differing from the accepted level flips it.
    bit m_db = 1'b1;
    int m_run = 0;
    bit m_hist[$] = '{1'b1, 1'b1};

    task automatic step(input bit r, input bit b);
        bit obs;
        @(negedge clk);
        rst = r;
        bus.B_raw = b;
        if (r) begin
            m_hist = '{1'b1, 1'b1};
            m_db = 1'b1;
            m_run = 0;
        end else begin
            obs = m_hist.pop_front();
            m_hist.push_back(b);
            if (obs != m_db) begin
                m_run++;
                if (m_run == S) begin
                    m_db = ~m_db;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        exp_q.push_back({m_db, (m_run > 0)});
    endtask

    task automatic hold(input bit r, input bit b, input int n);
        for (int i = 0; i < n; i++) step(r, b);
    endtask

    // Drive a new held level and measure edges until B_db reaches it;
    // edge 0 is the first edge after the change.
    task automatic measure(input string name, input bit lvl);
        int lat;
        lat = -1;
        step(1'b0, lvl);
        for (int k = 0; k < 4 * S + 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.B_db === lvl) begin
                lat = k;
                break;
            end
            step(1'b0, lvl);
        end
        checks++;
        if (lat != S + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, want %0d", name, lat, S + 1);
        end
    endtask

    // Monitor: one expectation per clock edge, compared just after the edge.
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.B_db !== e[1] || bus.busy !== e[0]) begin
                    errors++;
                    $display("FAIL edge_out t=%0t: B_db=%b busy=%b, want B_db=%b busy=%b",
                             $time, bus.B_db, bus.busy, e[1], e[0]);
                end
            end
        end
    end

    initial begin
        int len;
        bit lvl;
        bus.B_raw = 1'b1;
        hold(1'b1, 1'b1, 3);            // reset state
        hold(1'b0, 1'b1, 4);            // idle
        measure("press", 1'b0);         // clean press
        hold(1'b0, 1'b0, 3);
        measure("release", 1'b1);       // clean release
        hold(1'b0, 1'b1, 3);
        // press with one bounce: 0,0,1,0,0,...
        hold(1'b0, 1'b0, 2);
        step(1'b0, 1'b1);
        hold(1'b0, 1'b0, S + 6);
        // release bounces of 1..3 cycles, each rejected
        for (int k = 1; k < S; k++) begin
            hold(1'b0, 1'b1, k);
            hold(1'b0, 1'b0, S + 3);
        end
        hold(1'b0, 1'b1, S + 6);
        // short glitch low
        hold(1'b0, 1'b0, S - 1);
        hold(1'b0, 1'b1, S + 4);
        // reset mid-qualification (counter at 2), B_raw stays low
        hold(1'b0, 1'b0, 4);
        step(1'b1, 1'b0);
        hold(1'b0, 1'b0, S + 5);
        // reset while pressed, B_raw stays low
        step(1'b1, 1'b0);
        hold(1'b0, 1'b0, S + 5);
        hold(1'b0, 1'b1, S + 5);
        // random bounce soak
        for (int c = 0; c < 10000; c += len) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 2 * S + 2));
            if ($urandom_range(0, 199) == 0) step(1'b1, lvl);
            hold(1'b0, lvl, len);
        end
        hold(1'b0, 1'b1, 2);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
